// File: rtl/fifo_xfer_sched_if.sv
// Handshake bundle between the DMA FIFO transfer scheduler and its SCSI, host bus and FIFO counter neighbours.
// The master modport is the environment side; the slave modport is the scheduler side.
interface fifo_xfer_sched_if;
    logic       DMAENA;
    logic       DMADIR;
    logic       FLUSH;
    logic       SREQ;
    logic       SACK;
    logic       BREQ;
    logic       BDONE;
    logic       FIFOFULL;
    logic       FIFOEMPTY;
    logic       INCFIFO;
    logic       DECFIFO;
    logic [1:0] BPTR;
    logic       FLUSHED;
    logic       BERR;

    modport master (
        output DMAENA, DMADIR, FLUSH, SREQ, BDONE, FIFOFULL, FIFOEMPTY,
        input  SACK, BREQ, INCFIFO, DECFIFO, BPTR, FLUSHED, BERR
    );

    modport slave (
        input  DMAENA, DMADIR, FLUSH, SREQ, BDONE, FIFOFULL, FIFOEMPTY,
        output SACK, BREQ, INCFIFO, DECFIFO, BPTR, FLUSHED, BERR
    );
endinterface

// File: rtl/fifo_xfer_sched.sv
// Arbitrates the 8-longword DMA FIFO between SCSI bytes and host bus longwords, packs bytes via BPTR and flushes.
// Optional bus-cycle watchdog is compiled in with `define FIFO_WDOG_EN (limit WDOG_CYC clocks).
module fifo_xfer_sched #(
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic              CLK,
    input  logic              RESET_,
    fifo_xfer_sched_if.slave  xfer
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SBYTE  = 3'd1,
        ST_BWAIT  = 3'd2,
        ST_BDONE  = 3'd3,
        ST_PAD    = 3'd4,
        ST_SETTLE = 3'd5,
        ST_FDONE  = 3'd6
    } state_t;

    state_t     state_r;
    logic       sack_r;
    logic       breq_r;
    logic       inc_r;
    logic       dec_r;
    logic       flushed_r;
    logic [1:0] bptr_r;
    logic       rr_bus_r;
    logic       flush_pend_r;
    logic       berr_s;
    logic       go_s;
    logic       scsi_elig_s;
    logic       bus_elig_s;
    logic       grant_bus_s;

`ifdef FIFO_WDOG_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYC - 1);
    logic [7:0] wdog_cnt_r;
    logic       berr_r;
    assign berr_s = berr_r;
`else
    assign berr_s = 1'b0;
`endif

    assign xfer.SACK    = sack_r;
    assign xfer.BREQ    = breq_r;
    assign xfer.INCFIFO = inc_r;
    assign xfer.DECFIFO = dec_r;
    assign xfer.BPTR    = bptr_r;
    assign xfer.FLUSHED = flushed_r;
    assign xfer.BERR    = berr_s;

    assign go_s = xfer.DMAENA & ~berr_s;

    // Per-side eligibility; rr_bus_r picks the bus on a tie when the SCSI side was granted last
    always_comb begin
        scsi_elig_s = 1'b0;
        bus_elig_s  = 1'b0;
        if (xfer.DMADIR) begin
            scsi_elig_s = xfer.SREQ & ~xfer.FIFOFULL & ~flush_pend_r;
            bus_elig_s  = xfer.FIFOFULL | (flush_pend_r & ~xfer.FIFOEMPTY);
        end else begin
            scsi_elig_s = xfer.SREQ & ~xfer.FIFOEMPTY;
            bus_elig_s  = ~xfer.FIFOFULL;
        end
        grant_bus_s = bus_elig_s & (~scsi_elig_s | rr_bus_r);
    end

    // Transfer sequencer with registered handshake and FIFO counter pulses
    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            state_r      <= ST_IDLE;
            sack_r       <= 1'b0;
            breq_r       <= 1'b0;
            inc_r        <= 1'b0;
            dec_r        <= 1'b0;
            flushed_r    <= 1'b0;
            bptr_r       <= 2'd0;
            rr_bus_r     <= 1'b0;
            flush_pend_r <= 1'b0;
`ifdef FIFO_WDOG_EN
            wdog_cnt_r   <= 8'd0;
            berr_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        if (flush_pend_r && (bptr_r != 2'd0)) begin
                            state_r <= ST_PAD;
                            inc_r   <= 1'b1;
                            bptr_r  <= 2'd0;
                        end else if (flush_pend_r && xfer.FIFOEMPTY) begin
                            state_r   <= ST_FDONE;
                            flushed_r <= 1'b1;
                        end else if (grant_bus_s) begin
                            state_r  <= ST_BWAIT;
                            breq_r   <= 1'b1;
                            rr_bus_r <= 1'b0;
`ifdef FIFO_WDOG_EN
                            wdog_cnt_r <= 8'd0;
`endif
                        end else if (scsi_elig_s) begin
                            state_r  <= ST_SBYTE;
                            sack_r   <= 1'b1;
                            bptr_r   <= bptr_r + 2'd1;
                            rr_bus_r <= 1'b1;
                            if (bptr_r == 2'd3) begin
                                inc_r <= xfer.DMADIR;
                                dec_r <= ~xfer.DMADIR;
                            end
                        end
                    end
                end
                ST_SBYTE: begin
                    sack_r  <= 1'b0;
                    inc_r   <= 1'b0;
                    dec_r   <= 1'b0;
                    // bptr_r already wrapped to 0 exactly when this byte completed a longword
                    state_r <= (bptr_r == 2'd0) ? ST_SETTLE : ST_IDLE;
                end
                ST_BWAIT: begin
                    if (xfer.BDONE) begin
                        state_r <= ST_BDONE;
                        breq_r  <= 1'b0;
                        inc_r   <= ~xfer.DMADIR;
                        dec_r   <= xfer.DMADIR;
`ifdef FIFO_WDOG_EN
                    end else if (wdog_cnt_r == WDOG_LIMIT) begin
                        state_r <= ST_IDLE;
                        breq_r  <= 1'b0;
                        berr_r  <= 1'b1;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + 8'd1;
`endif
                    end
                end
                ST_BDONE, ST_PAD: begin
                    inc_r   <= 1'b0;
                    dec_r   <= 1'b0;
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (flush_pend_r && xfer.FIFOEMPTY && (bptr_r == 2'd0)) begin
                        state_r   <= ST_FDONE;
                        flushed_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FDONE: begin
                    flushed_r    <= 1'b0;
                    flush_pend_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    sack_r    <= 1'b0;
                    breq_r    <= 1'b0;
                    inc_r     <= 1'b0;
                    dec_r     <= 1'b0;
                    flushed_r <= 1'b0;
                end
            endcase
            // A flush request arriving mid-transfer stays pending until IDLE acts on it
            if (xfer.FLUSH && xfer.DMADIR) begin
                flush_pend_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_xfer_sched.sv
// Randomized scoreboard bench for fifo_xfer_sched: byte/longword model, FIFO counter model and bus responder.
module tb_fifo_xfer_sched;
    localparam int unsigned WDOG_CYC = 16;

    typedef struct packed {
        logic [1:0] bptr;
        logic       inc;
        logic       dec;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_;
    fifo_xfer_sched_if xf ();

    fifo_xfer_sched #(.WDOG_CYC(WDOG_CYC)) dut (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .xfer   (xf)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   sack_seen = 0;
    int   lw_cnt = 0;
    int   byte_pos = 0;
    bit   bus_en = 1'b0;
    bit   rr_chk = 1'b0;
    exp_t sack_q[$];
    bit   bus_q[$];
    bit   pad_q[$];
    bit   flush_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // External longword counter feeding the FIFO flags
    always @(posedge CLK) begin
        if (!RESET_) lw_cnt <= 0;
        else         lw_cnt <= lw_cnt + (xf.INCFIFO ? 1 : 0) - (xf.DECFIFO ? 1 : 0);
    end
    assign xf.FIFOFULL  = (lw_cnt == 8);
    assign xf.FIFOEMPTY = (lw_cnt == 0);

    // Byte-level reference: k-th byte lands in lane k mod 4, a longword completes on every 4th byte
    task automatic push_bytes(input int n, input bit dir);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            byte_pos = (byte_pos + 1) % 4;
            e.bptr = 2'(byte_pos);
            e.inc  = dir && (byte_pos == 0);
            e.dec  = !dir && (byte_pos == 0);
            sack_q.push_back(e);
        end
    endtask

    task automatic run_bytes(input int n, input int budget);
        int target;
        target = sack_seen + n;
        xf.SREQ = 1'b1;
        for (int c = 0; c < budget && sack_seen < target; c++) @(negedge CLK);
        xf.SREQ = 1'b0;
        check("sack_count", sack_seen, target);
    endtask

    task automatic do_flush(input int budget);
        if (byte_pos != 0) pad_q.push_back(1'b1);
        flush_q.push_back(1'b1);
        byte_pos = 0;
        xf.FLUSH = 1'b1;
        @(negedge CLK);
        xf.FLUSH = 1'b0;
        for (int c = 0; c < budget && flush_q.size() != 0; c++) @(negedge CLK);
        check("flush_done", flush_q.size(), 0);
    endtask

    // Host bus responder: answers BREQ after a random delay and records the expected counter pulse
    initial begin
        xf.BDONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus_en && xf.BREQ) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                if (xf.BREQ) begin
                    xf.BDONE = 1'b1;
                    bus_q.push_back(xf.DMADIR);
                    @(negedge CLK);
                    xf.BDONE = 1'b0;
                    @(negedge CLK);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows SACK, a counter pulse, a bus grant or FLUSHED
    initial begin
        exp_t e;
        bit   d;
        bit   prev_breq = 1'b0;
        bit   last_bus  = 1'b1;
        int   cyc = 0;
        int   last_pulse = -100;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET_) begin
                prev_breq  = 1'b0;
                last_bus   = 1'b1;
                last_pulse = -100;
            end else begin
                if (xf.INCFIFO || xf.DECFIFO) begin
                    check("pulse_excl", xf.INCFIFO & xf.DECFIFO, 0);
                    check("pulse_gap", (cyc - last_pulse) >= 2, 1);
                    last_pulse = cyc;
                end
                if (xf.SACK) begin
                    sack_seen++;
                    check("sack_expected", sack_q.size() != 0, 1);
                    if (sack_q.size() != 0) begin
                        e = sack_q.pop_front();
                        check("sack_bptr", xf.BPTR, e.bptr);
                        check("sack_inc", xf.INCFIFO, e.inc);
                        check("sack_dec", xf.DECFIFO, e.dec);
                    end
                    check("sack_flag", xf.DMADIR ? (lw_cnt < 8) : (lw_cnt > 0), 1);
                    if (rr_chk && lw_cnt > 0 && lw_cnt < 8) check("rr_alternate", 0, !last_bus);
                    last_bus = 1'b0;
                end else if (xf.INCFIFO || xf.DECFIFO) begin
                    check("pulse_expected", (bus_q.size() + pad_q.size()) != 0, 1);
                    if (bus_q.size() != 0) begin
                        d = bus_q.pop_front();
                        check("bus_dec", xf.DECFIFO, d);
                        check("bus_inc", xf.INCFIFO, !d);
                    end else if (pad_q.size() != 0) begin
                        void'(pad_q.pop_front());
                        check("pad_inc", xf.INCFIFO, 1);
                        check("pad_bptr", xf.BPTR, 0);
                    end
                end
                if (xf.BREQ && !prev_breq) begin
                    if (rr_chk && lw_cnt > 0 && lw_cnt < 8) check("rr_alternate", 1, !last_bus);
                    last_bus = 1'b1;
                end
                prev_breq = xf.BREQ;
                if (xf.FLUSHED) begin
                    check("flush_expected", flush_q.size() != 0, 1);
                    if (flush_q.size() != 0) void'(flush_q.pop_front());
                    check("flush_empty", lw_cnt, 0);
                    check("flush_bptr", xf.BPTR, 0);
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        int lens[4];
        int n0;
        int hi;
        RESET_    = 1'b0;
        xf.DMAENA = 1'b0;
        xf.DMADIR = 1'b1;
        xf.FLUSH  = 1'b0;
        xf.SREQ   = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_sack", xf.SACK, 0);
        check("rst_breq", xf.BREQ, 0);
        check("rst_inc", xf.INCFIFO, 0);
        check("rst_dec", xf.DECFIFO, 0);
        check("rst_bptr", xf.BPTR, 0);
        check("rst_flushed", xf.FLUSHED, 0);
        check("rst_berr", xf.BERR, 0);
        RESET_ = 1'b1;
        bus_en = 1'b1;
        @(negedge CLK);

        // SCSI -> memory: aligned, partial, random and overfilling runs, each closed by a flush
        lens[0] = 4;
        lens[1] = 6;
        lens[2] = $urandom_range(9, 31);
        lens[3] = $urandom_range(33, 44);
        xf.DMADIR = 1'b1;
        xf.DMAENA = 1'b1;
        foreach (lens[i]) begin
            push_bytes(lens[i], 1'b1);
            run_bytes(lens[i], 3000);
            do_flush(3000);
        end

        // Memory -> SCSI with SREQ held: grants must alternate while both sides are eligible
        xf.DMAENA = 1'b0;
        @(negedge CLK);
        xf.DMADIR = 1'b0;
        n0 = $urandom_range(13, 30);
        push_bytes(n0, 1'b0);
        xf.DMAENA = 1'b1;
        rr_chk = 1'b1;
        run_bytes(n0, 3000);
        xf.DMAENA = 1'b0;
        rr_chk = 1'b0;
        repeat (20) @(negedge CLK);
        check("bptr_hold", xf.BPTR, byte_pos);
        check("bus_q_idle", bus_q.size(), 0);

        // Reset while a bus cycle is outstanding
        bus_en = 1'b0;
        xf.DMADIR = (lw_cnt == 8);
        xf.DMAENA = 1'b1;
        for (int c = 0; c < 50 && !xf.BREQ; c++) @(negedge CLK);
        check("breq_before_rst", xf.BREQ, 1);
        repeat (2) @(negedge CLK);
        RESET_ = 1'b0;
        @(negedge CLK);
        check("rst_mid_breq", xf.BREQ, 0);
        check("rst_mid_bptr", xf.BPTR, 0);
        check("rst_mid_inc", xf.INCFIFO, 0);
        check("rst_mid_dec", xf.DECFIFO, 0);
        xf.DMAENA = 1'b0;
        byte_pos = 0;
        @(negedge CLK);
        RESET_ = 1'b1;
        bus_en = 1'b1;
        @(negedge CLK);

        // Recovery run after reset
        xf.DMADIR = 1'b1;
        xf.DMAENA = 1'b1;
        push_bytes(5, 1'b1);
        run_bytes(5, 500);
        do_flush(1000);
        repeat (5) @(negedge CLK);

`ifdef FIFO_WDOG_EN
        // Withheld BDONE: BERR after WDOG_CYC BWAIT cycles, then no more grants
        check("berr_before_wdog", xf.BERR, 0);
        bus_en = 1'b0;
        xf.DMAENA = 1'b0;
        @(negedge CLK);
        xf.DMADIR = 1'b0;
        xf.DMAENA = 1'b1;
        hi = 0;
        for (int c = 0; c < 100 && !xf.BERR; c++) begin
            @(negedge CLK);
            if (xf.BREQ) hi++;
        end
        check("wdog_breq_cycles", hi, WDOG_CYC);
        check("wdog_berr", xf.BERR, 1);
        check("wdog_breq_drop", xf.BREQ, 0);
        hi = 0;
        xf.SREQ = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (xf.BREQ || xf.SACK) hi++;
        end
        xf.SREQ = 1'b0;
        check("wdog_lockout", hi, 0);
        check("wdog_berr_sticky", xf.BERR, 1);
`else
        hi = 0;
        check("berr_tied", xf.BERR, 0);
`endif

        check("sack_q_drained", sack_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        check("pad_q_drained", pad_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_xfer_sched.md
Name: fifo_xfer_sched

Overview:
- Sequences and arbitrates the 8-longword DMA FIFO between the SCSI byte side and the host bus longword side.
- Generates the mutually exclusive INCFIFO/DECFIFO pulses that drive the FIFO full/empty counter, and consumes its FIFOFULL/FIFOEMPTY flags.
- Packs and unpacks SCSI bytes into longwords with a 2-bit byte pointer.
- Handles end-of-transfer flush, including a partial final longword.

Parameters:
- WDOG_CYC, 255: bus-cycle watchdog limit in CLK cycles. Used only with FIFO_WDOG_EN.

Ports:
- CLK  in  1  system clock. All logic on posedge.
- RESET_  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- DMAENA  in  1  transfer enable (level).
- DMADIR  in  1  1 = SCSI->memory (SCSI fills, bus drains); 0 = memory->SCSI (bus fills, SCSI drains). Static while DMAENA=1.
- FLUSH  in  1  flush request pulse. Meaningful only when DMADIR=1.
- SREQ  in  1  SCSI byte ready (dir 1) or byte wanted (dir 0).
- SACK  out  1  one-cycle byte-accept pulse.
- BREQ  out  1  host bus longword cycle request (level).
- BDONE  in  1  one-cycle bus cycle complete.
- FIFOFULL  in  1  from counter.
- FIFOEMPTY  in  1  from counter.
- INCFIFO  out  1  one-cycle pulse.
- DECFIFO  out  1  one-cycle pulse.
- BPTR  out  2  current byte lane within the longword.
- FLUSHED  out  1  one-cycle pulse when flush completes.
- BERR  out  1  watchdog error, sticky. Tied 0 without FIFO_WDOG_EN.

Behaviour:
- Reset (RESET_=0 at posedge): state IDLE; SACK, BREQ, INCFIFO, DECFIFO, FLUSHED, BERR = 0; BPTR = 0; round-robin pointer = SCSI; flush-pending = 0.
- Outputs are registered.
- INCFIFO and DECFIFO are never high in the same cycle.
- A new pulse on either is never issued before SETTLE has elapsed: flags settle on the negedge of the pulse cycle and are sampled one full cycle later.
- States: IDLE, SBYTE, BWAIT, BDONE_ST, PAD, SETTLE, FDONE.
- IDLE eligibility (evaluated only when DMAENA=1):
  - SCSI side, dir 1: SREQ & ~FIFOFULL & ~flush-pending.
  - SCSI side, dir 0: SREQ & ~FIFOEMPTY.
  - Bus side, dir 1: FIFOFULL, or flush-pending & ~FIFOEMPTY.
  - Bus side, dir 0: ~FIFOFULL.
  - If both sides are eligible, grant the side not granted last (round-robin). If only one is eligible, grant it. If neither, stay in IDLE.
- SBYTE (1 cycle):
  - SACK=1; BPTR <= BPTR+1, wrapping 3->0.
  - If BPTR was 3: pulse INCFIFO (dir 1) or DECFIFO (dir 0) in the same cycle, then go to SETTLE. Otherwise return to IDLE.
- BWAIT:
  - BREQ=1 until BDONE is sampled high, then go to BDONE_ST.
  - BDONE_ST: BREQ=0; pulse DECFIFO (dir 1) or INCFIFO (dir 0); then SETTLE.
- SETTLE: 1 cycle, no outputs asserted. Then IDLE, or FDONE when flush-pending and FIFOEMPTY.
- FLUSH (dir 1):
  - Sets flush-pending. FLUSH arriving during SBYTE/BWAIT is latched and acted on after the current transfer finishes.
  - From IDLE with flush-pending:
    - BPTR!=0: go to PAD (INCFIFO pulse, BPTR<=0), then SETTLE.
    - BPTR==0 and FIFOEMPTY: go to FDONE.
    - Otherwise: drain via the bus.
  - FDONE: FLUSHED=1 for 1 cycle; clear flush-pending; go to IDLE.
  - FLUSH with DMADIR=0 is ignored.
- DMAENA deasserted mid-transfer: the current SBYTE/BWAIT completes, including its INC/DEC pulse and SETTLE. Then hold in IDLE with BPTR preserved.
- RESET_ mid-operation: immediate synchronous return to reset values; BREQ drops the same edge.

Optional Feature:
- FIFO_WDOG_EN defined:
  - An 8-bit counter runs in BWAIT, cleared on entry.
  - When it reaches WDOG_CYC: BERR<=1 (sticky until reset), BREQ<=0, go to IDLE with no INC/DEC pulse.
  - While BERR=1, no further grants are made.
- Undefined: no counter; BERR tied 0; BWAIT waits indefinitely.

Test Plan:
- Dir 1, FIFO empty, 4 SREQ bytes -> 4 SACK pulses, BPTR 1,2,3,0, a single INCFIFO on the 4th byte, then 1 SETTLE cycle before the next SACK.
- Dir 1, 32 bytes -> FIFOFULL high, next SREQ held off (no SACK), BREQ asserted. BDONE -> DECFIFO, SACK resumes.
- Dir 0, FIFO partly full, SREQ held high, bus ready -> grants alternate SCSI/bus; INCFIFO and DECFIFO never coincide.
- Dir 1, 6 bytes then FLUSH -> PAD INCFIFO (BPTR 2->0), 2 BREQ/BDONE drains, FLUSHED pulse once FIFOEMPTY.
- RESET_ low during BWAIT -> next posedge BREQ=0, BPTR=0, state IDLE, no INC/DEC pulse.
- FIFO_WDOG_EN, WDOG_CYC=16, BDONE withheld -> BERR=1 at cycle 16 of BWAIT, BREQ=0, no further SACK/BREQ until reset.
